// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared state encoding and default timing constants for dds_trig_gen
package dds_pkg;

    // Default IO_UPDATE high width in clk cycles
    localparam int DDS_UPD_W     = 4;
    // Default cycles from IO_UPDATE falling to trig rising
    localparam int DDS_SETUP_CYC = 8;
    // Default width of the period / length counters
    localparam int DDS_CNT_W     = 32;
    // Width of the burst sweep count (DDS_TRIG_BURST_EN builds only)
    localparam int DDS_BURST_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UPD   = 3'd1,
        ST_SETUP = 3'd2,
        ST_SWEEP = 3'd3,
        ST_HOLD  = 3'd4
    } dds_state_t;

endpackage

// File: rtl/upd_pend_latch.sv
// rtl/upd_pend_latch.sv - sticky flag remembering that new DDS words still need an IO_UPDATE
module upd_pend_latch (
    input  logic clk,
    input  logic rst,
    input  logic i_set,
    input  logic i_clr,
    output logic o_pend
);

    logic r_pend;

    // Set has priority over clear so a request landing on the UPD entry is kept for the next PRT end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= i_set | (r_pend & ~i_clr);
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/dds_trig_gen.sv
// rtl/dds_trig_gen.sv - AD9914 IO_UPDATE / DRCTL / OSK strobe sequencer; optional burst mode via DDS_TRIG_BURST_EN
module dds_trig_gen
    import dds_pkg::*;
#(
    parameter int UPD_W     = DDS_UPD_W,
    parameter int SETUP_CYC = DDS_SETUP_CYC,
    parameter int CNT_W     = DDS_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [CNT_W-1:0]       prt_period,
    input  logic [CNT_W-1:0]       sweep_len,
    input  logic                   update_req,
`ifdef DDS_TRIG_BURST_EN
    input  logic [DDS_BURST_W-1:0] burst_num,
`endif
    output logic                   ad9914_update,
    output logic                   ad9914_trig,
    output logic                   ad9914_osk_temp,
    output logic                   busy,
    output logic                   sweep_done
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] UPD_LAST  = CNT_W'(UPD_W - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);

    dds_state_t       r_state;
    dds_state_t       w_next_state;

    logic [CNT_W-1:0] r_phase_cnt;
    logic [CNT_W-1:0] r_prt_cnt;
    logic [CNT_W-1:0] r_prt_period;
    logic [CNT_W-1:0] r_sweep_len;

    logic [CNT_W-1:0] w_len_eff;
    logic [CNT_W-1:0] w_nxt_prt_cnt;
    logic [CNT_W-1:0] w_nxt_len;

    logic             w_sweep_last;
    logic             w_no_hold;
    logic             w_hold_last;
    logic             w_prt_end;
    logic             w_enter_upd;
    logic             w_enter_sweep;
    logic             w_upd_pend;
    logic             w_burst_done;
    logic             w_start_ok;

    logic             r_update;
    logic             r_trig;
    logic             r_osk;
    logic             r_busy;
    logic             r_sweep_done;

    // A zero sweep length still produces a one-cycle sweep
    assign w_len_eff    = (sweep_len == '0) ? ONE : sweep_len;

    assign w_sweep_last = (r_prt_cnt == r_sweep_len - ONE);
    // When the period does not exceed the sweep, the PRT is exactly one sweep long
    assign w_no_hold    = (r_prt_period <= r_sweep_len);
    assign w_hold_last  = (r_prt_cnt == r_prt_period - ONE);

    upd_pend_latch u_upd_pend (
        .clk    (clk),
        .rst    (rst),
        .i_set  (update_req),
        .i_clr  (w_enter_upd),
        .o_pend (w_upd_pend)
    );

`ifdef DDS_TRIG_BURST_EN
    logic [DDS_BURST_W-1:0] r_burst_num;
    logic [DDS_BURST_W-1:0] r_sweep_cnt;
    logic                   r_burst_lock;

    // Sweep count includes the current sweep, so at PRT end equality means the burst is complete
    assign w_burst_done = (r_burst_num != '0) && (r_sweep_cnt == r_burst_num);
    // After a finished burst, run has to be seen low in IDLE before a new start is accepted
    assign w_start_ok   = ~r_burst_lock;

    // Burst bookkeeping: latch length at start, count sweep starts, lock out restart until run drops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_burst_num  <= '0;
            r_sweep_cnt  <= '0;
            r_burst_lock <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_enter_upd) begin
                r_burst_num <= burst_num;
                r_sweep_cnt <= '0;
            end else if (w_enter_sweep) begin
                r_sweep_cnt <= r_sweep_cnt + 1'b1;
            end
            if (w_prt_end && w_burst_done) begin
                r_burst_lock <= 1'b1;
            end else if (r_state == ST_IDLE && !run) begin
                r_burst_lock <= 1'b0;
            end
        end
    end
`else
    assign w_burst_done = 1'b0;
    assign w_start_ok   = 1'b1;
`endif

    // Next-state decode including the shared PRT-end decision
    always_comb begin
        w_next_state  = r_state;
        w_enter_upd   = 1'b0;
        w_enter_sweep = 1'b0;
        w_prt_end     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run && w_start_ok) begin
                    w_next_state = ST_UPD;
                    w_enter_upd  = 1'b1;
                end
            end
            ST_UPD: begin
                if (r_phase_cnt == UPD_LAST) begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_phase_cnt == SETUP_LAST) begin
                    w_next_state  = ST_SWEEP;
                    w_enter_sweep = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (w_sweep_last) begin
                    if (w_no_hold) begin
                        w_prt_end = 1'b1;
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_hold_last) begin
                    w_prt_end = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (w_prt_end) begin
            if (!run || w_burst_done) begin
                w_next_state = ST_IDLE;
            end else if (w_upd_pend) begin
                w_next_state = ST_UPD;
                w_enter_upd  = 1'b1;
            end else begin
                w_next_state  = ST_SWEEP;
                w_enter_sweep = 1'b1;
            end
        end
    end

    // Values the PRT counter and sweep length take in the next cycle, used to register sweep_done
    always_comb begin
        w_nxt_prt_cnt = w_enter_sweep ? '0 : r_prt_cnt + ONE;
        w_nxt_len     = w_enter_sweep ? w_len_eff : r_sweep_len;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Phase counter times UPD and SETUP; it restarts on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_phase_cnt <= '0;
        end else if (r_state == ST_UPD || r_state == ST_SETUP) begin
            r_phase_cnt <= r_phase_cnt + ONE;
        end else begin
            r_phase_cnt <= '0;
        end
    end

    // PRT counter starts at 0 on each sweep start and runs through SWEEP and HOLD only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prt_cnt <= '0;
        end else if (w_enter_sweep) begin
            r_prt_cnt <= '0;
        end else if (w_next_state == ST_SWEEP || w_next_state == ST_HOLD) begin
            r_prt_cnt <= r_prt_cnt + ONE;
        end else begin
            r_prt_cnt <= '0;
        end
    end

    // Timing inputs are captured only on UPD/SWEEP entry so mid-PRT changes wait for the next PRT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prt_period <= '0;
            r_sweep_len  <= ONE;
        end else if (w_enter_upd || w_enter_sweep) begin
            r_prt_period <= prt_period;
            r_sweep_len  <= w_len_eff;
        end
    end

    // Outputs are registered copies of the next-state decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_update     <= 1'b0;
            r_trig       <= 1'b0;
            r_osk        <= 1'b0;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b0;
        end else begin
            r_update     <= (w_next_state == ST_UPD);
            r_trig       <= (w_next_state == ST_SWEEP);
            r_osk        <= (w_next_state == ST_SWEEP);
            r_busy       <= (w_next_state != ST_IDLE);
            r_sweep_done <= (w_next_state == ST_SWEEP) && (w_nxt_prt_cnt == w_nxt_len - ONE);
        end
    end

    assign ad9914_update   = r_update;
    assign ad9914_trig     = r_trig;
    assign ad9914_osk_temp = r_osk;
    assign busy            = r_busy;
    assign sweep_done      = r_sweep_done;

endmodule

// File: tb/tb_dds_trig_gen.sv
// tb/tb_dds_trig_gen.sv - event scoreboard bench for dds_trig_gen
module tb_dds_trig_gen;

    localparam int UW = 4;
    localparam int SC = 8;

    localparam int K_BUSY_R = 0;
    localparam int K_BUSY_F = 1;
    localparam int K_UPD_R  = 2;
    localparam int K_UPD_F  = 3;
    localparam int K_TRIG_R = 4;
    localparam int K_TRIG_F = 5;
    localparam int K_OSK_R  = 6;
    localparam int K_OSK_F  = 7;
    localparam int K_DONE   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [31:0] prt_period;
    logic [31:0] sweep_len;
    logic        update_req;
`ifdef DDS_TRIG_BURST_EN
    logic [15:0] burst_num;
`endif
    logic        ad9914_update;
    logic        ad9914_trig;
    logic        ad9914_osk_temp;
    logic        busy;
    logic        sweep_done;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    logic p_upd = 1'b0, p_trig = 1'b0, p_osk = 1'b0, p_busy = 1'b0;

    dds_trig_gen #(.UPD_W(UW), .SETUP_CYC(SC), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .prt_period      (prt_period),
        .sweep_len       (sweep_len),
        .update_req      (update_req),
`ifdef DDS_TRIG_BURST_EN
        .burst_num       (burst_num),
`endif
        .ad9914_update   (ad9914_update),
        .ad9914_trig     (ad9914_trig),
        .ad9914_osk_temp (ad9914_osk_temp),
        .busy            (busy),
        .sweep_done      (sweep_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic ex(input int c, input int kind);
        exp_q.push_back(c * 16 + kind);
    endtask

    task automatic ex_prt(input int t0, input int len, input bit upd);
        if (upd) begin
            ex(t0 - (UW + SC), K_UPD_R);
            ex(t0 - SC, K_UPD_F);
        end
        ex(t0, K_TRIG_R);
        ex(t0, K_OSK_R);
        ex(t0 + len - 1, K_DONE);
        ex(t0 + len, K_TRIG_F);
        ex(t0 + len, K_OSK_F);
    endtask

    task automatic observe(input int kind);
        int ev;
        int want;
        ev = cyc * 16 + kind;
        n_cmp++;
        if (exp_q.size() == 0) want = -1;
        else want = exp_q.pop_front();
        assert (ev === want) else begin
            n_bad++;
            $error("FAIL event: observed cyc=%0d kind=%0d, expected cyc=%0d kind=%0d",
                   cyc, kind, want / 16, want % 16);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic end_scn(input string tag);
        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_bad++;
            $error("FAIL %s: %0d expected events never observed, expected 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_upd"},  {31'd0, ad9914_update},   32'd0);
        chk({tag, "_trig"}, {31'd0, ad9914_trig},     32'd0);
        chk({tag, "_osk"},  {31'd0, ad9914_osk_temp}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy},            32'd0);
        chk({tag, "_done"}, {31'd0, sweep_done},      32'd0);
    endtask

    // Edge monitor: every output transition is an event that must match the scoreboard head
    always @(negedge clk) begin
        if (busy === 1'b1 && p_busy === 1'b0) observe(K_BUSY_R);
        if (busy === 1'b0 && p_busy === 1'b1) observe(K_BUSY_F);
        if (ad9914_update === 1'b1 && p_upd === 1'b0) observe(K_UPD_R);
        if (ad9914_update === 1'b0 && p_upd === 1'b1) observe(K_UPD_F);
        if (ad9914_trig === 1'b1 && p_trig === 1'b0) observe(K_TRIG_R);
        if (ad9914_trig === 1'b0 && p_trig === 1'b1) observe(K_TRIG_F);
        if (ad9914_osk_temp === 1'b1 && p_osk === 1'b0) observe(K_OSK_R);
        if (ad9914_osk_temp === 1'b0 && p_osk === 1'b1) observe(K_OSK_F);
        if (sweep_done === 1'b1) observe(K_DONE);
        p_busy = busy;
        p_upd  = ad9914_update;
        p_trig = ad9914_trig;
        p_osk  = ad9914_osk_temp;
    end

    initial begin
        int s;
        int s2;
        rst        = 1'b0;
        run        = 1'b0;
        update_req = 1'b0;
        prt_period = 32'd100;
        sweep_len  = 32'd30;
`ifdef DDS_TRIG_BURST_EN
        burst_num  = 16'd0;
`endif
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_quiet("idle");

        // Single PRT with a one-cycle run pulse
        s = cyc;
        ex(s + 1, K_BUSY_R);
        ex_prt(s + 13, 30, 1'b1);
        ex(s + 113, K_BUSY_F);
        exp_q.sort();
        run = 1'b1;
        at(s + 1);
        run = 1'b0;
        at(s + 125);
        end_scn("single");

        // Continuous run, mid-PRT period glitch, update request in HOLD, run drop
        s = cyc;
        ex(s + 1, K_BUSY_R);
        ex_prt(s + 13,  30, 1'b1);
        ex_prt(s + 113, 30, 1'b0);
        ex_prt(s + 213, 30, 1'b0);
        ex_prt(s + 325, 30, 1'b1);
        ex_prt(s + 425, 30, 1'b0);
        ex_prt(s + 525, 30, 1'b0);
        ex(s + 625, K_BUSY_F);
        exp_q.sort();
        run = 1'b1;
        at(s + 20);
        prt_period = 32'd60;
        at(s + 30);
        prt_period = 32'd100;
        at(s + 260);
        update_req = 1'b1;
        at(s + 261);
        update_req = 1'b0;
        at(s + 530);
        run = 1'b0;
        at(s + 640);
        end_scn("continuous");

        // Zero sweep length behaves as one cycle
        prt_period = 32'd10;
        sweep_len  = 32'd0;
        s = cyc;
        ex(s + 1, K_BUSY_R);
        ex_prt(s + 13, 1, 1'b1);
        ex(s + 23, K_BUSY_F);
        exp_q.sort();
        run = 1'b1;
        at(s + 1);
        run = 1'b0;
        at(s + 30);
        end_scn("len_zero");

        // Period shorter than sweep: back-to-back sweeps, trig held high
        prt_period = 32'd20;
        sweep_len  = 32'd30;
        s = cyc;
        ex(s + 1, K_BUSY_R);
        ex(s + 1, K_UPD_R);
        ex(s + 5, K_UPD_F);
        ex(s + 13, K_TRIG_R);
        ex(s + 13, K_OSK_R);
        ex(s + 42, K_DONE);
        ex(s + 72, K_DONE);
        ex(s + 102, K_DONE);
        ex(s + 103, K_TRIG_F);
        ex(s + 103, K_OSK_F);
        ex(s + 103, K_BUSY_F);
        exp_q.sort();
        run = 1'b1;
        at(s + 90);
        run = 1'b0;
        at(s + 115);
        end_scn("prt_lt_len");

        // Asynchronous reset in the middle of a sweep, then restart with run held
        prt_period = 32'd100;
        sweep_len  = 32'd30;
        s = cyc;
        ex(s + 1, K_BUSY_R);
        ex(s + 1, K_UPD_R);
        ex(s + 5, K_UPD_F);
        ex(s + 13, K_TRIG_R);
        ex(s + 13, K_OSK_R);
        ex(s + 21, K_BUSY_F);
        ex(s + 21, K_TRIG_F);
        ex(s + 21, K_OSK_F);
        exp_q.sort();
        run = 1'b1;
        at(s + 20);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_quiet("async_rst");
        at(s + 24);
        rst = 1'b1;
        end_scn("reset_pre");
        s2 = cyc;
        ex(s2 + 1, K_BUSY_R);
        ex_prt(s2 + 13, 30, 1'b1);
        ex(s2 + 113, K_BUSY_F);
        exp_q.sort();
        at(s2 + 20);
        run = 1'b0;
        at(s2 + 125);
        end_scn("reset_restart");

`ifdef DDS_TRIG_BURST_EN
        // Burst of three sweeps, no restart while run stays high, then a one-sweep burst
        prt_period = 32'd40;
        sweep_len  = 32'd10;
        burst_num  = 16'd3;
        s = cyc;
        ex(s + 1, K_BUSY_R);
        ex_prt(s + 13, 10, 1'b1);
        ex_prt(s + 53, 10, 1'b0);
        ex_prt(s + 93, 10, 1'b0);
        ex(s + 133, K_BUSY_F);
        exp_q.sort();
        run = 1'b1;
        at(s + 200);
        end_scn("burst3");
        run = 1'b0;
        burst_num = 16'd1;
        at(s + 205);
        ex(s + 206, K_BUSY_R);
        ex_prt(s + 218, 10, 1'b1);
        ex(s + 258, K_BUSY_F);
        exp_q.sort();
        run = 1'b1;
        at(s + 210);
        run = 1'b0;
        at(s + 270);
        end_scn("burst1");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
